// File: rtl/regs_dump.sv
// regs_dump: debug reader for the picoMIPS register file. It freezes writes,
// walks read port 1 from FIRST_ADDR to 7 and streams (address, data) words.
`default_nettype none

module regs_dump #(
    parameter int n          = 8,
    parameter int FIRST_ADDR = 0
) (
    input  logic                clk,
    input  logic                n_reset,
    input  logic                start,
    output logic                busy,
    output logic                write_hold,
    output logic [2:0]          Raddr,
    input  logic signed [n-1:0] Rdata,
    output logic                dout_valid,
    input  logic                dout_ready,
    output logic [2:0]          dout_addr,
    output logic [n-1:0]        dout_data,
    output logic                dout_last,
    output logic                done
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] QUIESCE = 2'd1;
    localparam logic [1:0] FETCH   = 2'd2;
    localparam logic [1:0] SEND    = 2'd3;

    logic [1:0] state;
    logic [2:0] addr;

    // The read address comes straight from the counter register, so the
    // register file sees a glitch-free address for the whole FETCH cycle.
    assign Raddr      = addr;
    assign write_hold = busy;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state      <= IDLE;
            addr       <= 3'd0;
            busy       <= 1'b0;
            dout_valid <= 1'b0;
            dout_addr  <= 3'd0;
            dout_data  <= '0;
            dout_last  <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // A start coinciding with the done pulse is dropped.
                    if (start && !done) begin
                        state <= QUIESCE;
                        addr  <= 3'(FIRST_ADDR);
                        busy  <= 1'b1;
                    end
                end
                QUIESCE: begin
                    state <= FETCH;
                end
                FETCH: begin
                    dout_data  <= Rdata;
                    dout_addr  <= addr;
                    dout_valid <= 1'b1;
                    dout_last  <= (addr == 3'd7);
                    state      <= SEND;
                end
                SEND: begin
                    if (dout_ready) begin
                        dout_valid <= 1'b0;
                        if (dout_last) begin
                            dout_last <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            addr  <= addr + 3'd1;
                            state <= FETCH;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/regs_dump.md
Name: regs_dump

Overview:
- Debug reader for the 8-entry picoMIPS register file. On a start pulse it freezes datapath writes and walks the read address from FIRST_ADDR to 7.
- It captures each Rdata value and streams (address, data) pairs out over a valid/ready handshake.
- It sits beside the register file, sharing its read-port-1 address mux with the decoder. It feeds the board display or a UART formatter.

Parameters:
- n, 8, data width; matches register file width.
- FIRST_ADDR, 0, first register dumped (0..7). Register 0 reads as zero.

Ports:
- clk  input  1  system clock, rising edge.
- n_reset  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a dump; ignored unless idle.
- busy  output  1  high from the cycle after start is accepted until done.
- write_hold  output  1  high while busy; the CPU gates the register file write enable with it.
- Raddr  output  3  read address to register file port 1, valid while busy.
- Rdata  input  n  signed combinational read data from the register file.
- dout_valid  output  1  stream word valid.
- dout_ready  input  1  downstream accepts the word.
- dout_addr  output  3  register address of the current word.
- dout_data  output  n  captured register contents.
- dout_last  output  1  high with the word for address 7.
- done  output  1  one-cycle pulse after the last word transfers.

Behaviour:
- Reset (async, n_reset=0):
  - state=IDLE.
  - busy, write_hold, dout_valid, dout_last, done = 0.
  - Raddr, dout_addr, dout_data = 0.
- IDLE:
  - start=1 at a clock edge -> QUIESCE.
  - addr counter loads FIRST_ADDR.
  - busy and write_hold go 1 after that edge.
- QUIESCE:
  - Lasts exactly one cycle, so any register file write issued in the start cycle lands before the first read.
  - Next state is FETCH.
- FETCH:
  - Raddr = addr counter, driven from a register, so it is stable the whole cycle.
  - At the edge: dout_data <= Rdata, dout_addr <= addr, dout_valid <= 1, dout_last <= (addr==7).
  - Next state is SEND.
- SEND:
  - dout_valid, dout_addr, dout_data and dout_last are held stable until dout_valid && dout_ready at an edge.
  - On transfer with dout_last=0: dout_valid <= 0, addr <= addr+1, next state FETCH.
  - On transfer with dout_last=1: dout_valid <= 0, dout_last <= 0, busy <= 0, write_hold <= 0, done <= 1 for one cycle, next state IDLE.
- Throughput: with dout_ready tied high, each word takes 2 cycles (FETCH + SEND). A full dump with FIRST_ADDR=0 is start edge + 1 QUIESCE + 16 = 17 cycles to done.
- Address handling:
  - addr never wraps; the dump ends at 7.
  - FIRST_ADDR=7 produces one word with dout_last=1.
- start behaviour:
  - start while busy (including the done cycle) is ignored; no queuing.
  - start in the cycle after done starts a fresh dump normally.
- dout_ready may be high before dout_valid; no transfer occurs without valid. Valid never drops without a transfer.
- Register 0 data is whatever Rdata returns (0); no special-casing in this block.
- Async reset mid-dump: all outputs return to reset values immediately, write_hold is released, and no done pulse is produced.
- Register file contents are never modified by this block.

Test Plan:
1. Preload r1..r7 = 8'h11,8'h22,..,8'h77; pulse start; dout_ready=1 -> 8 words, addr 0..7, data 00,11,..,77; dout_last only on addr 7; done 17 cycles after the start edge; write_hold high throughout.
2. Same preload; dout_ready low for 3 cycles on each word -> every word held stable while stalled; no word lost or duplicated; done after 8 transfers.
3. CPU write r3 <= 8'hA5 in the same cycle as start -> dumped r3 = A5; CPU write attempted during the dump is blocked (write_hold=1); r5 is unchanged afterwards.
4. FIRST_ADDR=7, r7=8'h80 -> single word addr 7, data 80 (reads as -128 signed), dout_last=1; done pulses.
5. start pulsed again mid-dump and in the done cycle -> ignored; one dump only. A pulse one cycle after done starts a second dump with identical output.
6. n_reset asserted while in SEND at addr 4 -> busy, write_hold and dout_valid drop to 0 immediately with no done pulse. After release, a new start produces a complete dump from FIRST_ADDR.
